// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: forwarding select encodings,
// well-known register numbers and the forwarding priority helper.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUResultM

    localparam logic [3:0] REG_PC  = 4'd15;

    // The M stage holds the youngest result, so it wins over W when both match.
    function automatic logic [1:0] fwd_select(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       wr_m,
        input logic [3:0] wa_w,
        input logic       wr_w
    );
        if (wr_m && (ra == wa_m)) begin
            return FWD_MEM;
        end else if (wr_w && (ra == wa_w)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats increment; hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, PC-write
// stall/flush tracking via a shadow pipeline, and hazard perf counters.
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             PCSrcW,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic ldr_stall;
    logic pc_wr_pending;
    logic pc_e_q, pc_e_d;
    logic pc_m_q, pc_m_d;

    // Forwarding selects for both E-stage source operands.
    always_comb begin
        ForwardAE = fwd_select(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
        ForwardBE = fwd_select(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
    end

    // Stall/flush decisions; a PC write stays pending from D until it leaves M.
    always_comb begin
        ldr_stall     = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
        pc_wr_pending = PCSrcD || pc_e_q || pc_m_q;
        StallF        = ldr_stall || pc_wr_pending;
        StallD        = ldr_stall;
        FlushD        = pc_wr_pending || PCSrcW || BranchTakenE;
        FlushE        = ldr_stall || BranchTakenE;
    end

    // Shadow PC-write pipeline next state; a flushed D instruction never reaches E.
    always_comb begin
        pc_e_d = FlushE ? 1'b0 : PCSrcD;
        pc_m_d = pc_e_q;
    end

    // Shadow PC-write pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_e_q <= 1'b0;
            pc_m_q <= 1'b0;
        end else begin
            pc_e_q <= pc_e_d;
            pc_m_q <= pc_m_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (StallF),
        .clr   (CntClr),
        .count (StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (FlushE),
        .clr   (CntClr),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (counters narrowed to 4 bits).
module tb_hazard_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW, MemtoRegE, PCSrcD;
    logic             BranchTakenE, PCSrcW, CntClr;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks   = 0;
    int failures = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .PCSrcW       (PCSrcW),
        .CntClr       (CntClr),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd1; WA3M = 4'd0; WA3W = 4'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; BranchTakenE = 1'b0; PCSrcW = 1'b0; CntClr = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        clear_inputs();
        #2;
        chk("rst_stallcnt", 16'(StallCount), 16'd0);
        chk("rst_flushcnt", 16'(FlushCount), 16'd0);
        chk("rst_stallf",   16'(StallF),     16'd0);
        chk("rst_flushd",   16'(FlushD),     16'd0);
        chk("rst_fwda",     16'(ForwardAE),  16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ---------------- forwarding priority ----------------
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        RA2E = 4'd0;
        #1;
        chk("fwd_a_mem",  16'(ForwardAE), 16'b10);
        chk("fwd_b_none", 16'(ForwardBE), 16'b00);
        RegWriteM = 1'b0;
        #1;
        chk("fwd_a_wb", 16'(ForwardAE), 16'b01);
        RegWriteW = 1'b0;
        #1;
        chk("fwd_a_rf", 16'(ForwardAE), 16'b00);
        RegWriteM = 1'b1; RegWriteW = 1'b1; RA2E = 4'd7; WA3W = 4'd7;
        #1;
        chk("fwd_b_wb",  16'(ForwardBE), 16'b01);
        chk("fwd_a_mem2", 16'(ForwardAE), 16'b10);
        clear_inputs();

        // ---------------- load-use stall ----------------
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #1;
        chk("ldr_stallf", 16'(StallF), 16'd1);
        chk("ldr_stalld", 16'(StallD), 16'd1);
        chk("ldr_flushe", 16'(FlushE), 16'd1);
        chk("ldr_flushd", 16'(FlushD), 16'd0);
        tick();
        chk("ldr_stallcnt", 16'(StallCount), 16'd1);
        chk("ldr_flushcnt", 16'(FlushCount), 16'd1);
        clear_inputs();
        #1;
        chk("ldr_release", 16'(StallF), 16'd0);

        // ---------------- PC write through the shadow pipeline ----------------
        PCSrcD = 1'b1;
        #1;
        chk("pc_d_stallf", 16'(StallF), 16'd1);
        chk("pc_d_flushd", 16'(FlushD), 16'd1);
        chk("pc_d_flushe", 16'(FlushE), 16'd0);
        tick();
        PCSrcD = 1'b0;
        #1;
        chk("pc_e_stallf", 16'(StallF), 16'd1);
        chk("pc_e_flushd", 16'(FlushD), 16'd1);
        tick();
        #1;
        chk("pc_m_stallf", 16'(StallF), 16'd1);
        chk("pc_m_flushd", 16'(FlushD), 16'd1);
        tick();
        PCSrcW = 1'b1;
        #1;
        chk("pc_w_stallf", 16'(StallF), 16'd0);
        chk("pc_w_flushd", 16'(FlushD), 16'd1);
        PCSrcW = 1'b0;
        #1;
        chk("pc_idle_flushd", 16'(FlushD), 16'd0);
        chk("pc_stallcnt",    16'(StallCount), 16'd4);
        chk("pc_flushcnt",    16'(FlushCount), 16'd1);

        // ---------------- branch taken kills a D-stage PC write ----------------
        PCSrcD = 1'b1; BranchTakenE = 1'b1;
        #1;
        chk("br_flushe", 16'(FlushE), 16'd1);
        chk("br_flushd", 16'(FlushD), 16'd1);
        chk("br_stallf", 16'(StallF), 16'd1);
        tick();
        PCSrcD = 1'b0; BranchTakenE = 1'b0;
        #1;
        chk("br_after_stallf", 16'(StallF), 16'd0);
        tick();
        chk("br_after2_stallf", 16'(StallF), 16'd0);
        chk("br_stallcnt", 16'(StallCount), 16'd5);
        chk("br_flushcnt", 16'(FlushCount), 16'd2);

        // ---------------- load-use coincident with branch ----------------
        MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; BranchTakenE = 1'b1;
        #1;
        chk("both_flushe", 16'(FlushE), 16'd1);
        chk("both_stalld", 16'(StallD), 16'd1);
        chk("both_flushd", 16'(FlushD), 16'd1);
        tick();
        chk("both_stallcnt", 16'(StallCount), 16'd6);
        chk("both_flushcnt", 16'(FlushCount), 16'd3);
        clear_inputs();

        // ---------------- counter saturation and clear ----------------
        MemtoRegE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stallcnt", 16'(StallCount), 16'd15);
        chk("sat_flushcnt", 16'(FlushCount), 16'd15);
        CntClr = 1'b1;
        tick();
        chk("clr_stallcnt", 16'(StallCount), 16'd0);
        chk("clr_flushcnt", 16'(FlushCount), 16'd0);
        CntClr = 1'b0;
        tick();
        chk("post_clr_stallcnt", 16'(StallCount), 16'd1);
        clear_inputs();
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;

        // ---------------- async reset mid-operation ----------------
        BranchTakenE = 1'b1;
        tick();
        clear_inputs();
        MemtoRegE = 1'b1; WA3E = 4'd6; RA2D = 4'd6;
        for (int i = 0; i < 6; i++) tick();
        clear_inputs();
        PCSrcD = 1'b1;
        tick();
        PCSrcD = 1'b0;
        #1;
        chk("pre_rst_stallf",   16'(StallF),     16'd1);
        chk("pre_rst_stallcnt", 16'(StallCount), 16'd7);
        chk("pre_rst_flushcnt", 16'(FlushCount), 16'd7);
        reset = 1'b0;
        #1;
        chk("arst_stallcnt", 16'(StallCount), 16'd0);
        chk("arst_flushcnt", 16'(FlushCount), 16'd0);
        chk("arst_stallf",   16'(StallF),     16'd0);
        RA1E = 4'd9; WA3M = 4'd9; RegWriteM = 1'b1; PCSrcD = 1'b1;
        #1;
        chk("arst_fwda",   16'(ForwardAE), 16'b10);
        chk("arst_pcsrcd", 16'(StallF),    16'd1);
        tick();
        chk("arst_hold_stallcnt", 16'(StallCount), 16'd0);
        PCSrcD = 1'b0;
        #1;
        chk("arst_hold_stallf", 16'(StallF), 16'd0);
        clear_inputs();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard unit for the 5-stage ARM core. It sits downstream of the decode/execute controller: it consumes the controller's stage control bits and the datapath register addresses. It produces forwarding selects, stall and flush controls, including the FlushE that the controller's E-stage registers consume. It keeps its own shadow pipeline of in-flight PC writes and saturating hazard performance counters.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
RA1D  in  4  decode source register 1
RA2D  in  4  decode source register 2
RA1E  in  4  execute source register 1
RA2E  in  4  execute source register 2
WA3E  in  4  execute destination register
WA3M  in  4  memory destination register
WA3W  in  4  writeback destination register
RegWriteM  in  1  M-stage register write enable (post-condition)
RegWriteW  in  1  W-stage register write enable
MemtoRegE  in  1  E-stage instruction is a load
PCSrcD  in  1  decoded instruction writes PC (R15)
BranchTakenE  in  1  branch resolved taken in E
PCSrcW  in  1  W-stage PC write
CntClr  in  1  synchronous clear of both counters
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX registers (to controller)
StallCount  out  CNT_W  cycles with StallF=1
FlushCount  out  CNT_W  cycles with FlushE=1

Behaviour:
- Forwarding, combinational, same for A with RA1E and B with RA2E:
  - 10 if RegWriteM and RAxE==WA3M.
  - Else 01 if RegWriteW and RAxE==WA3W.
  - Else 00.
  - M takes priority when both stages match.
- ldrStall = MemtoRegE and (RA1D==WA3E or RA2D==WA3E).
- Shadow PC-write pipeline, two flops pcE and pcM:
  - Each clock: pcE <= FlushE ? 0 : PCSrcD.
  - Each clock: pcM <= pcE.
  - Both flops reset to 0 on reset=0.
- PCWrPending = PCSrcD or pcE or pcM.
- Stall and flush outputs, combinational:
  - StallF = ldrStall or PCWrPending.
  - StallD = ldrStall.
  - FlushD = PCWrPending or PCSrcW or BranchTakenE.
  - FlushE = ldrStall or BranchTakenE.
- Simultaneous ldrStall and BranchTakenE: FlushE=1, StallD=1, FlushD=1. Flush wins at IF/ID; the downstream flop handles clear over enable.
- Performance counters:
  - StallCount and FlushCount reset to 0.
  - On each clock edge: if CntClr, set to 0; else increment by 1 when StallF (respectively FlushE) is 1.
  - Saturate at 2^CNT_W-1 with no wrap. CntClr takes priority over increment.
- Reset mid-operation:
  - pcE, pcM and both counters clear immediately (asynchronous).
  - Combinational outputs keep tracking inputs during reset. PCWrPending reduces to PCSrcD.
- Latency:
  - Forward, stall and flush outputs have zero cycles of latency.
  - A PC write seen in D keeps StallF=1 for 3 consecutive cycles (D, E, M) if not flushed in E.
  - PCSrcW additionally drives FlushD in the 4th cycle.

Decomposition:
- Shared package (core_pkg) holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_PC=4'd15.
- Sub-module sat_counter (CNT_W param; inc, clr; async active-low reset) instantiated twice for StallCount and FlushCount.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Drop both -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1, FlushD=0, StallCount +1 that cycle.
- PC write: PCSrcD=1 for one cycle, then 0, no branch -> StallF=1 for exactly 3 cycles, FlushD=1 for those 3. With PCSrcW=1 in cycle 4 -> FlushD=1 in cycle 4.
- Branch taken: BranchTakenE=1 while PCSrcD=1 -> FlushE=1, FlushD=1. pcE stays 0 next cycle, so StallF drops after PCSrcD deasserts.
- Counter saturation: CNT_W=4, hold StallF=1 for 20 cycles -> StallCount reaches 15 and holds. Pulse CntClr with StallF=1 -> next value 0.
- Async reset: drive reset=0 mid-cycle with pcE=1 and counters=7 -> pcE=0 and counters=0 before the next clock edge. ForwardAE keeps following its inputs.
